// File: rtl/sum_window_accumulator_if.sv
// Sample-in / result-out handshake bundle for sum_window_accumulator.
// The slave modport is the accumulator; master is whoever drives and consumes it.
interface sum_window_accumulator_if #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int WINDOW    = 4,
  localparam int CW       = $clog2(WINDOW + 1)
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_sum;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_acc;
  logic [CW-1:0]        out_count;
  logic                 out_overflow;

  modport master (
    output in_valid, in_sum, flush, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_sum, flush, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_overflow
  );
endinterface

// File: rtl/sum_window_accumulator.sv
// Accumulates unsigned sum samples over a fixed window (or an early flush)
// and presents total, sample count and carry-out flag on a valid/ready output.
module sum_window_accumulator #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int WINDOW    = 4,
  localparam int CW       = $clog2(WINDOW + 1)
) (
  input logic                     clk,
  input logic                     rst,
  sum_window_accumulator_if.slave bus
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t               state, state_next;
  logic [ACC_WIDTH-1:0] acc, acc_next;
  logic [CW-1:0]        count, count_next;
  logic                 overflow, overflow_next;
  logic [ACC_WIDTH:0]   sum_wide;
  logic                 accept;

  // Handshake outputs come only from registered state (plus reset gating).
  assign bus.in_ready  = (state == ACCUM) && !rst;
  assign bus.out_valid = (state == HOLD);

  assign accept   = bus.in_valid && bus.in_ready;
  assign sum_wide = {1'b0, acc} + (ACC_WIDTH + 1)'(bus.in_sum);

  always_comb begin
    state_next    = state;
    acc_next      = acc;
    count_next    = count;
    overflow_next = overflow;
    case (state)
      ACCUM: begin
        if (accept) begin
          acc_next      = sum_wide[ACC_WIDTH-1:0];
          overflow_next = overflow | sum_wide[ACC_WIDTH];
          count_next    = count + CW'(1);
        end
        // Flush closes the window only if it would carry at least one sample.
        if (count_next == CW'(WINDOW) || (bus.flush && count_next != '0))
          state_next = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_next    = ACCUM;
          acc_next      = '0;
          count_next    = '0;
          overflow_next = 1'b0;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      acc      <= acc_next;
      count    <= count_next;
      overflow <= overflow_next;
    end
  end

  assign bus.out_acc      = (state == HOLD) ? acc      : '0;
  assign bus.out_count    = (state == HOLD) ? count    : '0;
  assign bus.out_overflow = (state == HOLD) ? overflow : 1'b0;

endmodule

// File: tb/tb_sum_window_accumulator.sv
// Drives an 8-bit and a 5-bit accumulator with identical stimulus and compares
// every cycle against a window-of-samples reference model.
module tb_sum_window_accumulator;

  localparam int WINDOW = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sum_window_accumulator_if #(.WIDTH(4), .ACC_WIDTH(8), .WINDOW(WINDOW)) bus8 ();
  sum_window_accumulator_if #(.WIDTH(4), .ACC_WIDTH(5), .WINDOW(WINDOW)) bus5 ();

  sum_window_accumulator #(.WIDTH(4), .ACC_WIDTH(8), .WINDOW(WINDOW)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  sum_window_accumulator #(.WIDTH(4), .ACC_WIDTH(5), .WINDOW(WINDOW)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the samples of the current window and whether it is being held.
  int q[$];
  bit holding = 1'b0;

  function automatic int windowTotal();
    int t = 0;
    foreach (q[i]) t += q[i];
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs,
  // then advance the model across the rising edge.
  task automatic applyStimulus(input bit v, input int s, input bit f, input bit ordy, input bit r, input bit chk);
    int total;
    @(negedge clk);
    rst            = r;
    bus8.in_valid  = v;  bus5.in_valid  = v;
    bus8.in_sum    = 4'(s); bus5.in_sum = 4'(s);
    bus8.flush     = f;  bus5.flush     = f;
    bus8.out_ready = ordy; bus5.out_ready = ordy;
    #1;
    if (chk) begin
      total = holding ? windowTotal() : 0;
      checkOutput("in_ready8",   32'(bus8.in_ready),  32'(!holding && !r));
      checkOutput("in_ready5",   32'(bus5.in_ready),  32'(!holding && !r));
      checkOutput("out_valid8",  32'(bus8.out_valid), 32'(holding));
      checkOutput("out_valid5",  32'(bus5.out_valid), 32'(holding));
      checkOutput("out_acc8",    32'(bus8.out_acc),   32'(total % 256));
      checkOutput("out_acc5",    32'(bus5.out_acc),   32'(total % 32));
      checkOutput("out_count8",  32'(bus8.out_count), holding ? 32'(q.size()) : 32'd0);
      checkOutput("out_count5",  32'(bus5.out_count), holding ? 32'(q.size()) : 32'd0);
      checkOutput("out_ovf8",    32'(bus8.out_overflow), 32'(total >= 256));
      checkOutput("out_ovf5",    32'(bus5.out_overflow), 32'(total >= 32));
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      holding = 1'b0;
    end else if (holding) begin
      if (ordy) begin
        holding = 1'b0;
        q.delete();
      end
    end else begin
      if (v) q.push_back(s & 15);
      if (q.size() == WINDOW || (f && q.size() > 0)) holding = 1'b1;
    end
  endtask

  task automatic feed(input int s);
    applyStimulus(1'b1, s, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    // Power-up: outputs are unknown until the first reset edge.
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1);

    // Full window; also wraps the 5-bit instance on the 15s.
    feed(1); feed(2); feed(3); feed(4);
    idle(2);
    feed(15); feed(15); feed(15); feed(15);
    idle(1);
    feed(1); feed(1); feed(1); feed(1);
    idle(2);

    // Backpressure while upstream keeps offering 9.
    feed(2); feed(2); feed(2); feed(2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Flush alone, then flush concurrent with an accept.
    feed(7); feed(8);
    applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(2);
    feed(5); feed(5);
    applyStimulus(1'b1, 5, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Flush with nothing collected is ignored.
    applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Reset in the middle of a window discards it.
    feed(3); feed(3); feed(3);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    feed(1); feed(1); feed(1); feed(1);
    idle(2);

    // Randomized traffic with occasional flush, backpressure and reset.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom % 4) != 0, int'($urandom % 16), ($urandom % 8) == 0,
                    ($urandom % 3) != 0, ($urandom % 60) == 0, 1'b1);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
